// File: rtl/button_event_arbiter.sv
// Front-panel event arbiter: debouncer sample tick, pending/overflow
// capture and round-robin valid/ready event serialisation.
module button_event_arbiter #(
   parameter int N        = 4,
   parameter int IDW      = 2,
   parameter int TICK_DIV = 50000
) (
   input  logic           Clk,
   input  logic           rst,
   input  logic [N-1:0]   btn_pulse,
   output logic           sample_tick,
   output logic           ev_valid,
   input  logic           ev_ready,
   output logic [IDW-1:0] ev_id,
   output logic [N-1:0]   pending,
   output logic [N-1:0]   ovf,
   input  logic           ovf_clr
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);
   localparam logic [N-1:0] ONE = N'(1);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [CW-1:0]  r_cnt;
   logic           r_tick;
   logic [N-1:0]   r_pend;
   logic [N-1:0]   r_ovf;
   logic [IDW-1:0] r_id;
   logic [IDW-1:0] r_last;
   logic [IDW-1:0] w_id_nxt;
   logic [IDW-1:0] w_last_nxt;
   logic [IDW-1:0] w_pick;
   logic           w_found;
   logic           w_hs;
   logic [N-1:0]   w_clr;
   logic [N-1:0]   w_pend_nxt;
   logic [N-1:0]   w_ovf_nxt;

   assign sample_tick = r_tick;
   assign ev_valid    = (r_state == OFFER);
   assign ev_id       = r_id;
   assign pending     = r_pend;
   assign ovf         = r_ovf;

   assign w_hs       = ev_valid & ev_ready;
   assign w_clr      = w_hs ? (ONE << r_id) : '0;
   assign w_pend_nxt = (r_pend & ~w_clr) | btn_pulse;
   // A new overflow beats a same-cycle clear request
   assign w_ovf_nxt  = (ovf_clr ? '0 : r_ovf)
                     | (btn_pulse & r_pend & ~w_clr);

   // Scan above last grant first, then wrap to the low indices
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_last;
      for (int i = 0; i < N; i++) begin
         if (!w_found && r_pend[i] && (IDW'(i) > r_last)) begin
            w_found = 1'b1;
            w_pick  = IDW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!w_found && r_pend[i] && (IDW'(i) <= r_last)) begin
            w_found = 1'b1;
            w_pick  = IDW'(i);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_id_nxt    = r_id;
      w_last_nxt  = r_last;
      unique case (r_state)
         IDLE: begin
            if (w_found) begin
               w_id_nxt    = w_pick;
               w_state_nxt = OFFER;
            end
         end
         OFFER: begin
            if (ev_ready) begin
               w_last_nxt  = r_id;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_id    <= '0;
         r_last  <= IDW'(N - 1);
         r_pend  <= '0;
         r_ovf   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_id    <= w_id_nxt;
         r_last  <= w_last_nxt;
         r_pend  <= w_pend_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= (r_cnt == CMAX) ? '0 : r_cnt + CW'(1);
         r_tick <= (r_cnt == CMAX);
      end
   end

endmodule
